// File: rtl/add_pkg.sv
// Shared encodings and configuration checks for the pipelined adder.
package add_pkg;

    localparam logic SUB_ADD = 1'b0;
    localparam logic SUB_SUB = 1'b1;

    function automatic bit width_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width != 0) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB for overflow.
module add_chunk
    import add_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] sum_full;

    assign sum_full = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, ci};
    assign s        = sum_full[CHUNK-1:0];
    assign co       = sum_full[CHUNK];

    if (CHUNK > 1) begin : g_msb
        logic [CHUNK-1:0] sum_lo;
        assign sum_lo = {1'b0, a_c[CHUNK-2:0]} + {1'b0, b_c[CHUNK-2:0]} + {{(CHUNK-1){1'b0}}, ci};
        assign c_msb  = sum_lo[CHUNK-1];
    end else begin : g_msb_bit
        assign c_msb = ci;
    end

endmodule

// File: rtl/add_n_pipe.sv
// Pipelined add/subtract, CHUNK bits resolved per stage, valid/ready on both sides.
module add_n_pipe
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("add_n_pipe: WIDTH must be a positive multiple of CHUNK");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign b_eff = (sub == SUB_SUB) ? ~b : b;
    assign c_eff = (sub == SUB_SUB) ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned WU = WIDTH - k * CHUNK;  // operand bits not yet consumed
        localparam int unsigned WR = (k + 1) * CHUNK;    // result bits resolved here

        logic [WU-1:0]    a_up, b_up;
        logic             c_up, v_up;
        logic [CHUNK-1:0] s;
        logic             co, c_msb;
        logic [WR-1:0]    res_d, res_q;
        logic             v_q, co_q;
        logic             adv;

        if (k == 0) begin : g_head
            assign a_up  = a;
            assign b_up  = b_eff;
            assign c_up  = c_eff;
            assign v_up  = in_valid;
            assign res_d = s;
        end else begin : g_body
            assign a_up  = g_stg[k-1].g_fwd.a_q;
            assign b_up  = g_stg[k-1].g_fwd.b_q;
            assign c_up  = g_stg[k-1].co_q;
            assign v_up  = g_stg[k-1].v_q;
            assign res_d = {s, g_stg[k-1].res_q};
        end

        add_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a_c  (a_up[CHUNK-1:0]),
            .b_c  (b_up[CHUNK-1:0]),
            .ci   (c_up),
            .s    (s),
            .co   (co),
            .c_msb(c_msb)
        );

        // An empty upstream clears valid but leaves the data untouched.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                res_q <= '0;
                co_q  <= 1'b0;
            end else if (adv) begin
                v_q <= v_up;
                if (v_up) begin
                    res_q <= res_d;
                    co_q  <= co;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WU-CHUNK-1:0] a_q, b_q;
            logic                unused_c_msb;

            assign unused_c_msb = c_msb;
            assign adv          = !v_q || g_stg[k+1].adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_up) begin
                    a_q <= a_up[WU-1:CHUNK];
                    b_q <= b_up[WU-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf_q;

            assign adv = !v_q || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_up) begin
                    ovf_q <= c_msb ^ co;
                end
            end
        end
    end

    assign in_ready  = g_stg[0].adv;
    assign out_valid = g_stg[STAGES-1].v_q;
    assign out       = g_stg[STAGES-1].res_q;
    assign cout      = g_stg[STAGES-1].co_q;
    assign ovf       = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_add_n_pipe.sv
// Directed bench for add_n_pipe at WIDTH=16, CHUNK=4 (four stages).
module tb_add_n_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         cout, ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add_n_pipe #(
        .WIDTH(16),
        .CHUNK(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .cout     (cout),
        .ovf      (ovf)
    );

    // Behavioural reference: {ovf, cout, out}
    function automatic logic [W+1:0] model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                           input logic c_v, input logic s_v);
        logic [W-1:0] bp;
        logic         c0;
        logic [W:0]   full;
        logic [W-1:0] lo;
        bp   = s_v ? ~b_v : b_v;
        c0   = s_v ? ~c_v : c_v;
        full = {1'b0, a_v} + {1'b0, bp} + {{W{1'b0}}, c0};
        lo   = {1'b0, a_v[W-2:0]} + {1'b0, bp[W-2:0]} + {{(W-1){1'b0}}, c0};
        return {lo[W-1] ^ full[W], full[W], full[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out !== 16'h0000) begin
            failures++; $display("FAIL reset_out got=%h exp=0000", out);
        end
        checks++;
        if (cout !== 1'b0) begin
            failures++; $display("FAIL reset_cout got=%b exp=0", cout);
        end
        checks++;
        if (ovf !== 1'b0) begin
            failures++; $display("FAIL reset_ovf got=%b exp=0", ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // add, full carry chain, subtract with signed overflow
    task automatic test_directed();
        logic [W-1:0] ta  [3] = '{16'h00FF, 16'hFFFF, 16'h8000};
        logic [W-1:0] tbv [3] = '{16'h0001, 16'h0001, 16'h0001};
        logic         tc  [3] = '{1'b0, 1'b1, 1'b0};
        logic         ts  [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] to  [3] = '{16'h0100, 16'h0001, 16'h7FFF};
        logic         tco [3] = '{1'b0, 1'b1, 1'b1};
        logic         tov [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            in_valid = 1'b1; a = ta[i]; b = tbv[i]; cin = tc[i]; sub = ts[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL dir%0d_in_ready got=%b exp=1", i, in_ready);
            end
            step();
            in_valid = 1'b0;
            step();
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL dir%0d_early_valid got=%b exp=0", i, out_valid);
            end
            step();
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL dir%0d_latency_valid got=%b exp=1", i, out_valid);
            end
            checks++;
            if (out !== to[i]) begin
                failures++; $display("FAIL dir%0d_out got=%h exp=%h", i, out, to[i]);
            end
            checks++;
            if (cout !== tco[i]) begin
                failures++; $display("FAIL dir%0d_cout got=%b exp=%b", i, cout, tco[i]);
            end
            checks++;
            if (ovf !== tov[i]) begin
                failures++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, tov[i]);
            end
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL dir%0d_dup_valid got=%b exp=0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] va [20];
        logic [W-1:0] vb [20];
        logic         vc [20];
        logic         vs [20];
        logic [W+1:0] ex [20];
        int  wr = 0, rd = 0, inflight;
        bit  saw_full = 0, resumed, fire_in, fire_out;
        logic exp_rdy;
        for (int i = 0; i < 20; i++) begin
            va[i] = W'($urandom); vb[i] = W'($urandom);
            vc[i] = 1'($urandom_range(1)); vs[i] = 1'($urandom_range(1));
            ex[i] = model(va[i], vb[i], vc[i], vs[i]);
        end
        for (int cyc = 0; cyc < 150 && rd < 20; cyc++) begin
            out_ready = !(cyc >= 8 && cyc < 16);
            resumed   = (cyc >= 16);
            if (wr < 20) begin
                in_valid = 1'b1; a = va[wr]; b = vb[wr]; cin = vc[wr]; sub = vs[wr];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            inflight = wr - rd;
            exp_rdy  = out_ready || (inflight < 4);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
            end
            if (!out_ready && !in_ready) saw_full = 1;
            if (resumed) begin
                checks++;
                if (out_valid !== (inflight > 0)) begin
                    failures++;
                    $display("FAIL bp_gap cyc=%0d got=%b exp=%b", cyc, out_valid, inflight > 0);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (rd >= 20) begin
                    failures++; $display("FAIL bp_extra cyc=%0d got=valid exp=idle", cyc);
                end else if ({ovf, cout, out} !== ex[rd]) begin
                    failures++;
                    $display("FAIL bp_result idx=%0d got=%h exp=%h", rd, {ovf, cout, out}, ex[rd]);
                end
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            @(posedge clk);
            #1;
            if (fire_in)  wr++;
            if (fire_out) rd++;
        end
        in_valid = 1'b0;
        checks++;
        if (rd != 20) begin
            failures++; $display("FAIL bp_count got=%0d exp=20", rd);
        end
        checks++;
        if (!saw_full) begin
            failures++; $display("FAIL bp_in_ready_fell got=0 exp=1");
        end
    endtask

    task automatic test_reset_midflight();
        bit got_out = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'h1000 + 16'(i); b = 16'h0101; cin = 1'b0; sub = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out !== 16'h0000) begin
            failures++; $display("FAIL mid_async_out got=%h exp=0000", out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_async_in_ready got=%b exp=1", in_ready);
        end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid !== 1'b0) got_out = 1;
        end
        checks++;
        if (got_out) begin
            failures++; $display("FAIL mid_ghost_output got=1 exp=0");
        end
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_fresh_early got=%b exp=0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 16'h2345 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL mid_fresh_result got=%b/%h/%b/%b exp=1/2345/0/0",
                     out_valid, out, cout, ovf);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_n_pipe.md
# add_n_pipe

- Parametrised, pipelined successor to the 4-bit ripple adder `add_4`.
- Adds or subtracts two WIDTH-bit operands with carry/borrow in, processing CHUNK bits per pipeline stage.
- Uses a valid/ready handshake on both sides and produces one result per cycle at full throughput.
- Sits between operand producers and result consumers that may stall.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 4, bits resolved per stage; STAGES = WIDTH/CHUNK

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin, 1: a−b−cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result, mod 2^WIDTH
- cout  out  1  raw carry out of bit WIDTH−1 (sub: 1 = no borrow)
- ovf  out  1  signed overflow

## Operation
- Accept on a rising edge with in_valid && in_ready. Capture a, b, cin and sub together.
- Effective operands: B' = sub ? ~b : b, c0 = sub ? ~cin : cin, giving a + B' + c0. In sub mode this is a − b − cin.
- Stage k (0..STAGES−1) adds chunk k, bits [k·CHUNK +: CHUNK], with the carry from stage k−1. Stage 0 uses c0.
- Each stage register holds: valid, the result bits produced so far, the unconsumed high bits of a and B', the carry out, and the carry into the MSB (meaningful at the last stage only).
- Arithmetic is unsigned modulo 2^WIDTH. cout is the carry out of the top chunk.
- ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Per-stage flow control: stage k advances when !valid_k || advance_{k+1}. The last stage advances when !out_valid || out_ready.
- in_ready = stage 0 advance condition. It is combinational from out_ready through the stage valids, and this path is accepted.
- A stage loads data only when it advances. When it advances with an empty upstream, it clears its valid bit and holds its data.
- out, cout and ovf are driven directly from the last-stage registers. They stay stable while out_valid && !out_ready.
- No reordering, loss or duplication. Capacity is STAGES results in flight.
- Reset: all valid bits 0 and all data registers 0, so out=0, cout=0, ovf=0 and out_valid=0. With all stages empty, in_ready=1.

## Timing
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES−1, i.e. STAGES edges after the capture edge, provided there is no stall.
- Throughput: one beat per cycle while out_ready=1.
- Stall, out_ready=0:
  - Bubbles collapse first.
  - in_ready falls only once every stage is valid.
  - in_ready rises in the same cycle out_ready returns to 1.
- Simultaneous accept and emit with the pipe full: allowed, because in_ready follows out_ready combinationally.
- Reset mid-operation: rst_n low clears everything asynchronously, so out_valid drops without waiting for a clock. In-flight beats are discarded and nothing is emitted after release until new beats are accepted.
- WIDTH = CHUNK degenerates to a single registered stage with latency 1.

## Structure
- Package add_pkg holds the mode encodings, SUB_ADD=1'b0 and SUB_SUB=1'b1, plus the elaboration check function `width_ok(WIDTH, CHUNK)`.
- Sub-module add_chunk: a combinational CHUNK-bit adder with inputs a_c, b_c, ci and outputs s, co, c_msb (carry into its MSB). It is instantiated once per stage in a generate loop.
- The top level holds the stage registers, valid chain and handshake logic.
- The bench compares results against a behavioural model computing {cout, out} = a + B' + c0 and ovf.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, STAGES=4.
- Reset: rst_n=0 → out_valid=0, out=16'h0000, cout=0, ovf=0, in_ready=1.
- Add: a=16'h00FF, b=16'h0001, cin=0, sub=0, accepted at edge t, out_ready=1 → after edge t+3: out_valid=1, out=16'h0100, cout=0, ovf=0.
- Carry chain across all chunks: a=16'hFFFF, b=16'h0001, cin=1, sub=0 → out=16'h0001, cout=1, ovf=0.
- Subtract with signed overflow: a=16'h8000, b=16'h0001, cin=0, sub=1 → out=16'h7FFF, cout=1, ovf=1.
- Backpressure:
  - Stimulus: 20 back-to-back random beats with mixed sub/cin; out_ready is held 0 for 8 cycles mid-stream.
  - Required: in_ready falls after 4 beats are buffered.
  - Required: out stays stable while stalled.
  - Required: all 20 results arrive in order and match the model, with no gaps once out_ready=1.
- Reset mid-flight: 3 beats in flight, rst_n pulsed low between edges → out_valid falls immediately (asynchronously); no result is emitted after release; a fresh beat then completes with latency 4.
